// File: rtl/id_hazard_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// id_hazard_scoreboard_pkg
// Shared definitions for the decode-stage hazard scoreboard.
//   - Register-file geometry (NUM_REGS, REG_IDX_W) and counter widths.
//   - Named special-register indices (SP, IH, T, RA) mapped above R0-R7.
//   - Scoreboard FSM state encoding.
//   - reg_onehot(): index-to-one-hot decoder with enable, used to steer
//     issue increments and write-back decrements to the per-register counters.
// No ports (package).
// -----------------------------------------------------------------------------
package id_hazard_scoreboard_pkg;

    localparam int NUM_REGS    = 16;
    localparam int REG_IDX_W   = 4;
    localparam int CNT_W       = 2;
    localparam int STALL_MAX   = 64;
    localparam int RUN_CNT_W   = 7;
    localparam int STALL_CNT_W = 16;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // Special registers live directly above the eight general registers.
    localparam reg_idx_t REG_SP = 4'd8;
    localparam reg_idx_t REG_IH = 4'd9;
    localparam reg_idx_t REG_T  = 4'd10;
    localparam reg_idx_t REG_RA = 4'd11;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } sb_state_e;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_idx_t idx,
                                                       input logic     en);
        logic [NUM_REGS-1:0] v;
        v      = '0;
        v[idx] = en;
        return v;
    endfunction

endpackage

// File: rtl/id_hazard_scoreboard_sb_counter.sv
// -----------------------------------------------------------------------------
// sb_counter
// One pending-write counter for a single architectural register.
// Ports:
//   clk_i        in   clock
//   rst_i        in   synchronous active-high reset (count -> 0)
//   inc_i        in   an instruction writing this register issues this cycle
//   dec_i        in   a write-back to this register retires this cycle
//   pend_o       out  register has an outstanding write that a reader must
//                     wait for (the same-cycle write-back is already applied
//                     when WB_BYPASS is set)
//   full_o       out  another writer cannot be tracked this cycle
//   busy_o       out  registered count is non-zero
//   underflow_o  out  write-back arrived while nothing was pending
// -----------------------------------------------------------------------------
module sb_counter #(
    parameter int CNT_W     = 2,
    parameter int WB_BYPASS = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic pend_o,
    output logic full_o,
    output logic busy_o,
    output logic underflow_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dec_ok;
    logic             inc_ok;

    always_comb begin
        // A write-back with nothing pending is dropped (and reported).
        dec_ok = dec_i & (cnt_q != '0);
        // Increment at the ceiling is only legal when a write-back frees a slot.
        inc_ok = inc_i & ((cnt_q != CNT_MAX) | dec_ok);
        cnt_d  = cnt_q;
        if (inc_ok && !dec_ok) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (dec_ok && !inc_ok) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        busy_o      = (cnt_q != '0);
        // The register file writes before it reads, so the last outstanding
        // write retiring this cycle no longer blocks a reader.
        pend_o      = busy_o & ~((WB_BYPASS != 0) & dec_i & (cnt_q == CNT_ONE));
        // Same-cycle write-back is applied before the saturation check.
        full_o      = (cnt_q == CNT_MAX) & ~dec_i;
        underflow_o = dec_i & (cnt_q == '0);
    end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// id_hazard_scoreboard
// Decode-stage issue controller. Tracks in-flight register writes with one
// pending counter per register and decides, in the same cycle, whether the
// instruction in ID may issue into ID/EX.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   id_valid_i              decoded instruction present in ID
//   id_rs1_i/id_rs1_used_i  source 1 index / source 1 is read
//   id_rs2_i/id_rs2_used_i  source 2 index / source 2 is read
//   id_wr_en_i/id_wr_reg_i  instruction writes a register / destination index
//   flush_i                 squash the ID slot this cycle
//   wb_valid_i/wb_reg_i     write-back retiring this cycle / its destination
//   id_ready_o              instruction issues this cycle
//   stall_if_o              hold PC and IF/ID
//   bubble_ex_o             load a NOP into ID/EX
//   busy_mask_o             bit r set while register r has pending writes
//   stall_cnt_o             saturating count of stall cycles
//   sb_err_o                sticky: write-back underflow or stall timeout
//   dbg_state_o             current RUN/STALL state
//
// Handshake: id_valid_i is the decoder's offer; id_ready_o is the acceptance.
// A transfer happens exactly on a cycle where both are high. id_ready_o is
// never high without id_valid_i, and the decoder must hold the same
// instruction while stall_if_o is high. flush_i withdraws the offer for the
// cycle regardless of hazards.
// -----------------------------------------------------------------------------
module id_hazard_scoreboard
    import id_hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS_P = NUM_REGS,
    parameter int CNT_W_P    = CNT_W,
    parameter int WB_BYPASS  = 1,
    parameter int STALL_MAX_P = STALL_MAX
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   id_valid_i,
    input  logic [REG_IDX_W-1:0]   id_rs1_i,
    input  logic                   id_rs1_used_i,
    input  logic [REG_IDX_W-1:0]   id_rs2_i,
    input  logic                   id_rs2_used_i,
    input  logic                   id_wr_en_i,
    input  logic [REG_IDX_W-1:0]   id_wr_reg_i,
    input  logic                   flush_i,
    input  logic                   wb_valid_i,
    input  logic [REG_IDX_W-1:0]   wb_reg_i,
    output logic                   id_ready_o,
    output logic                   stall_if_o,
    output logic                   bubble_ex_o,
    output logic [NUM_REGS_P-1:0]  busy_mask_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o,
    output logic                   sb_err_o,
    output sb_state_e              dbg_state_o
);

    // ------------------------------------------------------------------
    // Per-register pending counters
    // ------------------------------------------------------------------
    logic [NUM_REGS_P-1:0] inc_vec;
    logic [NUM_REGS_P-1:0] dec_vec;
    logic [NUM_REGS_P-1:0] pend_vec;
    logic [NUM_REGS_P-1:0] full_vec;
    logic [NUM_REGS_P-1:0] busy_vec;
    logic [NUM_REGS_P-1:0] uf_vec;
    logic                  hazard;
    logic                  issue;

    always_comb begin
        inc_vec = NUM_REGS_P'(reg_onehot(id_wr_reg_i, issue & id_wr_en_i));
        dec_vec = NUM_REGS_P'(reg_onehot(wb_reg_i, wb_valid_i));
    end

    for (genvar g = 0; g < NUM_REGS_P; g++) begin : g_cnt
        sb_counter #(
            .CNT_W     (CNT_W_P),
            .WB_BYPASS (WB_BYPASS)
        ) u_cnt (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .inc_i       (inc_vec[g]),
            .dec_i       (dec_vec[g]),
            .pend_o      (pend_vec[g]),
            .full_o      (full_vec[g]),
            .busy_o      (busy_vec[g]),
            .underflow_o (uf_vec[g])
        );
    end

    // ------------------------------------------------------------------
    // Hazard detection and issue control (combinational, zero latency)
    // ------------------------------------------------------------------
    always_comb begin
        hazard = (id_rs1_used_i & pend_vec[id_rs1_i])
               | (id_rs2_used_i & pend_vec[id_rs2_i])
               | (id_wr_en_i    & full_vec[id_wr_reg_i]);
        issue       = id_valid_i & ~hazard & ~flush_i;
        id_ready_o  = issue;
        stall_if_o  = id_valid_i & hazard & ~flush_i;
        bubble_ex_o = ~issue;
        busy_mask_o = busy_vec;
    end

    // ------------------------------------------------------------------
    // RUN/STALL FSM with consecutive-stall watchdog
    // ------------------------------------------------------------------
    sb_state_e              state_q;
    sb_state_e              state_d;
    logic [RUN_CNT_W-1:0]   run_cnt_q;
    logic [RUN_CNT_W-1:0]   run_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d;
    logic                   sb_err_q;
    logic                   sb_err_d;
    logic                   stall_timeout;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (stall_if_o)  state_d = ST_STALL;
            ST_STALL: if (!stall_if_o) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        // The run counter counts every cycle that lands in STALL and is
        // cleared whenever the FSM goes (or stays) in RUN. It holds at its
        // ceiling so a very long stall cannot wrap back under the limit.
        run_cnt_d = '0;
        if (state_d == ST_STALL) begin
            run_cnt_d = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + RUN_CNT_W'(1);
        end
        stall_timeout = (run_cnt_d >= RUN_CNT_W'(STALL_MAX_P));

        stall_cnt_d = stall_cnt_q;
        if (stall_if_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end

        sb_err_d = sb_err_q | (|uf_vec) | stall_timeout;

        stall_cnt_o = stall_cnt_q;
        sb_err_o    = sb_err_q;
        dbg_state_o = state_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            run_cnt_q   <= '0;
            stall_cnt_q <= '0;
            sb_err_q    <= 1'b0;
        end else begin
            run_cnt_q   <= run_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            sb_err_q    <= sb_err_d;
        end
    end

endmodule
